// File: rtl/uart_tx.sv
`timescale 1ns/1ps
// uart_tx: 8-bit serial transmitter paced by an external baud waveform.
// Frame: start, 8 data LSB first, optional parity, 1-2 stop bits.
module uart_tx #(
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       baud_in,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       tx_out,
  output logic       tx_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ALIGN,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  localparam bit   LP_PEN   = (PARITY_EN != 0);
  localparam logic LP_ODD   = 1'(PARITY_ODD);
  localparam logic LP_SLAST = 1'(STOP_BITS - 1);

  state_t     r_state;
  state_t     w_next;
  logic [7:0] r_shift;
  logic [7:0] w_shift_nx;
  logic [2:0] r_cnt;
  logic [2:0] w_cnt_nx;
  logic       r_scnt;
  logic       w_scnt_nx;
  logic       r_par;
  logic       w_par_nx;
  logic       r_tx_out;
  logic       w_tx_nx;
  logic       r_done;
  logic       w_done_nx;

  logic       r_sync1;
  logic       r_sync2;
  logic       r_hist;
  logic       r_seen;
  logic       r_armed;
  logic       w_tick;

  // A baud_in already high at reset release must not look like an edge:
  // ticks are enabled only after a real low sample has been seen.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_hist  <= 1'b0;
      r_seen  <= 1'b0;
      r_armed <= 1'b0;
    end else begin
      r_sync1 <= baud_in;
      r_sync2 <= r_sync1;
      r_hist  <= r_sync2;
      r_seen  <= 1'b1;
      r_armed <= r_armed | (r_seen & ~r_sync1);
    end
  end

  assign w_tick = r_sync2 & ~r_hist & r_armed;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_shift  <= 8'h00;
      r_cnt    <= 3'd0;
      r_scnt   <= 1'b0;
      r_par    <= 1'b0;
      r_tx_out <= 1'b1;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_shift  <= w_shift_nx;
      r_cnt    <= w_cnt_nx;
      r_scnt   <= w_scnt_nx;
      r_par    <= w_par_nx;
      r_tx_out <= w_tx_nx;
      r_done   <= w_done_nx;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_shift_nx = r_shift;
    w_cnt_nx   = r_cnt;
    w_scnt_nx  = r_scnt;
    w_par_nx   = r_par;
    w_done_nx  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (tx_valid) begin
          w_next     = S_ALIGN;
          w_shift_nx = tx_data;
          w_cnt_nx   = 3'd0;
          w_par_nx   = (^tx_data) ^ LP_ODD;
        end
      end
      S_ALIGN: begin
        if (w_tick) w_next = S_START;
      end
      S_START: begin
        if (w_tick) w_next = S_DATA;
      end
      S_DATA: begin
        if (w_tick) begin
          w_shift_nx = r_shift >> 1;
          w_cnt_nx   = r_cnt + 3'd1;
          w_scnt_nx  = 1'b0;
          if (r_cnt == 3'd7) begin
            w_next = LP_PEN ? S_PARITY : S_STOP;
          end
        end
      end
      S_PARITY: begin
        if (w_tick) begin
          w_next    = S_STOP;
          w_scnt_nx = 1'b0;
        end
      end
      S_STOP: begin
        if (w_tick) begin
          if (r_scnt == LP_SLAST) begin
            w_next    = S_IDLE;
            w_done_nx = 1'b1;
          end else begin
            w_scnt_nx = r_scnt + 1'b1;
          end
        end
      end
      default: w_next = S_IDLE;
    endcase

    // Line level is registered from the state being entered.
    case (w_next)
      S_START:  w_tx_nx = 1'b0;
      S_DATA:   w_tx_nx = w_shift_nx[0];
      S_PARITY: w_tx_nx = w_par_nx;
      default:  w_tx_nx = 1'b1;
    endcase
  end

  assign tx_ready = (r_state == S_IDLE);
  assign tx_out   = r_tx_out;
  assign tx_done  = r_done;

endmodule
